fcmp_issue: RTL and testbench

- Sequential front-end that turns single-precision compare/select instructions into fcmp transactions and turns the fcmp flag outputs back into architectural results.
- Accepts one request on a valid/ready handshake and registers the operands onto an external combinational fcmp instance.
- Samples that instance's unordered/altb/blta/aeqb flags and returns a 32-bit result plus an invalid-operation (NV) flag on a valid/ready response port.
- Sits between the FPU issue logic and the fcmp unit; keeps a sticky NV status bit.

---
 rtl/fcmp_issue.sv | 184 ++++++++++++++++++
 tb/tb_fcmp_issue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fcmp_issue.sv
// fcmp_issue: issues FEQ/FLT/FLE/FMIN/FMAX to an external combinational
// fcmp, folds its flags into a result, and keeps a sticky NV flag.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   req_valid/req_ready          request handshake
//   req_op, req_a, req_b         opcode and IEEE-754 single operands
//   cmp_opa, cmp_opb             latched operands to the fcmp instance
//   cmp_unordered/altb/blta/aeqb fcmp flags, valid while in CMP
//   rsp_valid/rsp_ready          response handshake
//   rsp_data, rsp_nv             result and invalid-operation flag
//   rsp_illegal                  request opcode was undefined
//   fflags_clr, fflags_nv        sticky NV clear and status
module fcmp_issue #(
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] cmp_opa,
  output logic [31:0] cmp_opb,
  input  logic        cmp_unordered,
  input  logic        cmp_altb,
  input  logic        cmp_blta,
  input  logic        cmp_aeqb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_nv,
  output logic        rsp_illegal,
  input  logic        fflags_clr,
  output logic        fflags_nv
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_FEQ  = 3'b000;
  localparam logic [2:0] OP_FLT  = 3'b001;
  localparam logic [2:0] OP_FLE  = 3'b010;
  localparam logic [2:0] OP_FMIN = 3'b011;
  localparam logic [2:0] OP_FMAX = 3'b100;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] data_q, data_d;
  logic        nv_q, nv_d;
  logic        ill_q, ill_d;
  logic        sticky_q, sticky_d;

  logic        a_nan, b_nan, a_snan, b_snan;
  logic        any_nan, any_snan, unord;
  logic [31:0] res_data;
  logic        res_nv, res_ill;

  assign a_nan    = (&a_q[30:23]) & (|a_q[22:0]);
  assign b_nan    = (&b_q[30:23]) & (|b_q[22:0]);
  assign a_snan   = a_nan & ~a_q[22];
  assign b_snan   = b_nan & ~b_q[22];
  assign any_nan  = a_nan | b_nan;
  assign any_snan = a_snan | b_snan;
  // No ordering flag at all is treated as unordered too.
  assign unord    = any_nan | cmp_unordered
                  | ~(cmp_altb | cmp_blta | cmp_aeqb);

  always_comb begin
    res_data = '0;
    res_nv   = 1'b0;
    res_ill  = 1'b0;
    unique case (op_q)
      OP_FEQ: begin
        res_data[0] = cmp_aeqb & ~unord;
        res_nv      = any_snan;
      end
      OP_FLT: begin
        res_data[0] = cmp_altb & ~unord;
        res_nv      = any_nan;
      end
      OP_FLE: begin
        res_data[0] = (cmp_altb | cmp_aeqb) & ~unord;
        res_nv      = any_nan;
      end
      OP_FMIN, OP_FMAX: begin
        res_nv = any_snan;
        if (a_nan && b_nan)
          res_data = CANON_NAN;
        else if (a_nan)
          res_data = b_q;
        else if (b_nan)
          res_data = a_q;
        else if (cmp_altb)
          res_data = (op_q == OP_FMIN) ? a_q : b_q;
        else if (cmp_blta)
          res_data = (op_q == OP_FMIN) ? b_q : a_q;
        else if (cmp_aeqb) begin
          // +0 vs -0: pick by sign; otherwise A.
          if (a_q[31] != b_q[31])
            res_data = ((op_q == OP_FMIN) == a_q[31])
                     ? a_q : b_q;
          else
            res_data = a_q;
        end else
          res_data = CANON_NAN;
      end
      default: res_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    data_d   = data_q;
    nv_d     = nv_q;
    ill_d    = ill_q;
    sticky_d = fflags_clr ? 1'b0 : sticky_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        data_d  = res_data;
        nv_d    = res_nv;
        ill_d   = res_ill;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          if (nv_q)
            sticky_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      data_q   <= '0;
      nv_q     <= 1'b0;
      ill_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      data_q   <= data_d;
      nv_q     <= nv_d;
      ill_q    <= ill_d;
      sticky_q <= sticky_d;
    end
  end

  assign req_ready   = rst_n & (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_DONE);
  assign rsp_data    = data_q;
  assign rsp_nv      = nv_q;
  assign rsp_illegal = ill_q;
  assign fflags_nv   = sticky_q;
  assign cmp_opa     = a_q;
  assign cmp_opb     = b_q;

endmodule

// File: tb/tb_fcmp_issue.sv
// tb_fcmp_issue: directed vectors for fcmp_issue with a behavioural
// fcmp model, plus backpressure and mid-transaction reset sequences.
module tb_fcmp_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [31:0] cmp_opa, cmp_opb;
  logic        cmp_unordered, cmp_altb, cmp_blta, cmp_aeqb;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_nv, rsp_illegal;
  logic        fflags_clr = 1'b0;
  logic        fflags_nv;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fcmp_issue dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .cmp_opa(cmp_opa), .cmp_opb(cmp_opb),
    .cmp_unordered(cmp_unordered), .cmp_altb(cmp_altb),
    .cmp_blta(cmp_blta), .cmp_aeqb(cmp_aeqb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_nv(rsp_nv),
    .rsp_illegal(rsp_illegal),
    .fflags_clr(fflags_clr), .fflags_nv(fflags_nv)
  );

  // Behavioural combinational fcmp.
  function automatic logic [31:0] okey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  always_comb begin
    logic an, bn;
    an = (&cmp_opa[30:23]) & (|cmp_opa[22:0]);
    bn = (&cmp_opb[30:23]) & (|cmp_opb[22:0]);
    cmp_unordered = an | bn;
    cmp_altb = 1'b0;
    cmp_blta = 1'b0;
    cmp_aeqb = 1'b0;
    if (!(an | bn)) begin
      if (cmp_opa[30:0] == 0 && cmp_opb[30:0] == 0)
        cmp_aeqb = 1'b1;
      else begin
        cmp_altb = okey(cmp_opa) < okey(cmp_opb);
        cmp_blta = okey(cmp_opa) > okey(cmp_opb);
        cmp_aeqb = cmp_opa == cmp_opb;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        nv;
    logic        il;
  } vec_t;

  vec_t vt[$];

  // Issue one request; returns captured response and latency.
  task automatic txn(input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, output logic [31:0] d,
                     output logic nv, output logic il,
                     output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    req_op = op;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = rsp_data;
    nv = rsp_nv;
    il = rsp_illegal;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic nv, il, sticky;
    int lat;

    vt.push_back('{3'd1, 32'h3F800000, 32'h40000000, 32'h1, 1'b0, 1'b0});
    vt.push_back('{3'd2, 32'h40000000, 32'h40000000, 32'h1, 1'b0, 1'b0});
    vt.push_back('{3'd0, 32'h7FC00000, 32'h3F800000, 32'h0, 1'b0, 1'b0});
    vt.push_back('{3'd1, 32'h7FC00000, 32'h3F800000, 32'h0, 1'b1, 1'b0});
    vt.push_back('{3'd0, 32'h7F800001, 32'h3F800000, 32'h0, 1'b1, 1'b0});
    vt.push_back('{3'd3, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0});
    vt.push_back('{3'd4, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0});
    vt.push_back('{3'd4, 32'hC0000000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0});
    vt.push_back('{3'd4, 32'h7F800001, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0});
    vt.push_back('{3'd3, 32'h7FC00000, 32'h7F800001, 32'h7FC00000, 1'b1, 1'b0});
    vt.push_back('{3'd2, 32'h40400000, 32'h40000000, 32'h0, 1'b0, 1'b0});
    vt.push_back('{3'd3, 32'hC0000000, 32'h3F800000, 32'hC0000000, 1'b0, 1'b0});
    vt.push_back('{3'd3, 32'hBF800000, 32'hC0000000, 32'hC0000000, 1'b0, 1'b0});
    vt.push_back('{3'd0, 32'h00000000, 32'h80000000, 32'h1, 1'b0, 1'b0});
    vt.push_back('{3'd1, 32'h7F800000, 32'h7F800000, 32'h0, 1'b0, 1'b0});
    vt.push_back('{3'd2, 32'h7F800000, 32'h7F800000, 32'h1, 1'b0, 1'b0});
    vt.push_back('{3'd4, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0});
    vt.push_back('{3'd5, 32'h3F800000, 32'h40000000, 32'h0, 1'b0, 1'b1});

    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_fflags", fflags_nv, 0);
    chk("rst_opa", cmp_opa, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);

    sticky = 1'b0;
    foreach (vt[i]) begin
      txn(vt[i].op, vt[i].a, vt[i].b, d, nv, il, lat);
      sticky |= vt[i].nv;
      chk($sformatf("v%0d_data", i), d, vt[i].d);
      chk($sformatf("v%0d_nv", i), nv, vt[i].nv);
      chk($sformatf("v%0d_ill", i), il, vt[i].il);
      chk($sformatf("v%0d_lat", i), lat, 2);
      chk($sformatf("v%0d_sticky", i), fflags_nv, sticky);
      chk($sformatf("v%0d_opa_hold", i), cmp_opa, vt[i].a);
    end

    // Clear sticky, then backpressure an NV result.
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    chk("clr_sticky", fflags_nv, 0);
    req_op = 3'd1;
    req_a = 32'h7FC00000;
    req_b = 32'h3F800000;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_valid", rsp_valid, 1);
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_data", rsp_data, 0);
      chk("bp_hold_nv", rsp_nv, 1);
      chk("bp_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    fflags_clr = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    fflags_clr = 1'b0;
    chk("bp_set_wins", fflags_nv, 1);
    chk("bp_after_valid", rsp_valid, 0);
    chk("bp_after_ready", req_ready, 1);

    // Reset during CMP.
    req_op = 3'd3;
    req_a = 32'h40000000;
    req_b = 32'h3F800000;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_req_ready", req_ready, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_fflags", fflags_nv, 0);
    chk("mr_opa", cmp_opa, 0);
    chk("mr_opb", cmp_opb, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mr_no_rsp", rsp_valid, 0);
    end
    chk("mr_ready", req_ready, 1);

    txn(3'b111, 32'h3F800000, 32'h3F800000, d, nv, il, lat);
    chk("ill_flag", il, 1);
    chk("ill_data", d, 0);
    chk("ill_nv", nv, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
